// File: rtl/gray_feeder.sv
// gray_feeder: drains 24-bit RGB pixels from an upstream FWFT FIFO and
// converts each one to 8-bit grayscale, gray = floor((R+G+B)/3). The result
// is pushed into the Sobel input FIFO. A raster position is tracked so the
// push of the last pixel of each frame can be flagged.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_rd_en   out  pop request to upstream RGB FIFO
//   in_empty   in   upstream FIFO empty
//   in_dout    in   FWFT head pixel {R[23:16], G[15:8], B[7:0]}
//   out_wr_en  out  push strobe to Sobel input FIFO
//   out_full   in   Sobel input FIFO full
//   out_din    out  grayscale pixel (S2 register)
//   frame_done out  pulse with the push of the last pixel of a frame
//   busy       out  any pipeline stage holds a valid pixel
module gray_feeder #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [23:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [7:0]  out_din,
  output logic        frame_done,
  output logic        busy
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  // r_vld_pipe[1] = S1 valid, r_vld_pipe[2] = S2 valid
  logic [2:1]    r_vld_pipe;
  logic [9:0]    r_sum;
  logic [7:0]    r_gray;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic          w_adv;
  logic          w_rd;
  logic [9:0]    w_sum;
  logic [20:0]   w_prod;
  logic [7:0]    w_gray;

  // The whole pipe stalls only when S2 holds a pixel that cannot be pushed.
  assign w_adv = !(r_vld_pipe[2] && out_full);
  assign w_rd  = w_adv && !in_empty && !reset;

  assign w_sum = {2'b00, in_dout[23:16]} + {2'b00, in_dout[15:8]} + {2'b00, in_dout[7:0]};

  // 683/2048 exceeds 1/3 by 1/6144; for sum <= 765 the excess stays below
  // the smallest fractional gap (1/3), so the floor is exact.
  assign w_prod = 21'(r_sum) * 21'd683;
  assign w_gray = 8'(w_prod >> 11);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_sum      <= '0;
      r_gray     <= '0;
    end else if (w_adv) begin
      r_vld_pipe[1] <= w_rd;
      if (w_rd) r_sum <= w_sum;
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) r_gray <= w_gray;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (out_wr_en) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign in_rd_en   = w_rd;
  assign out_wr_en  = r_vld_pipe[2] && !out_full;
  assign out_din    = r_gray;
  assign frame_done = out_wr_en && (r_x == X_LAST) && (r_y == Y_LAST);
  assign busy       = |r_vld_pipe;

endmodule

// File: tb/tb_gray_feeder.sv
module tb_gray_feeder;
  localparam int W = 4;
  localparam int H = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_rd_en;
  logic        in_empty;
  logic [23:0] in_dout;
  logic        out_wr_en;
  logic        out_full;
  logic [7:0]  out_din;
  logic        frame_done;
  logic        busy;

  always #5 clock = ~clock;

  gray_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .frame_done(frame_done), .busy(busy)
  );

  typedef struct { int g; int cyc; } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [23:0] src[$];
  int          cyc = 0, wcnt = 0, fd_cnt = 0, wr_cnt = 0;
  bit          starve = 0, chk_lat = 0, fullp = 0, prev_full = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gref(input logic [23:0] p);
    return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
  endfunction

  // One clock: drive at posedge+1, observe at negedge, transfer at posedge.
  task automatic cycle_once();
    exp_t e;
    in_empty = starve || (src.size() == 0);
    in_dout  = (src.size() != 0) ? src[0] : 24'h0;
    out_full = fullp;
    @(negedge clock);
    chk("busy", busy, int'(sb.size() != 0));
    if (out_full) chk("wr_stall", out_wr_en, 0);
    if (out_full && sb.size() == 2) chk("rd_stall", in_rd_en, 0);
    if (prev_full && !out_full && sb.size() == 2) chk("release_wr", out_wr_en, 1);
    if (in_empty) chk("rd_empty", in_rd_en, 0);
    if (out_wr_en) begin
      wr_cnt++;
      if (sb.size() == 0) chk("spurious_wr", out_wr_en, 0);
      else begin
        e = sb.pop_front();
        chk("dout", out_din, e.g);
        if (chk_lat) chk("latency", cyc - e.cyc, 2);
        wcnt++;
        chk("frame_done", frame_done, int'((wcnt % (W*H)) == 0));
        if (frame_done) fd_cnt++;
      end
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
    if (in_rd_en && !in_empty) begin
      sb.push_back('{gref(src[0]), cyc});
      void'(src.pop_front());
    end
    prev_full = out_full;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (src.size() == 0 && sb.size() == 0) break;
      cycle_once();
    end
    chk("drain_left", sb.size() + src.size(), 0);
    cycle_once();
    cycle_once();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_rd", in_rd_en, 0);
    chk("rst_wr", out_wr_en, 0);
    chk("rst_dout", out_din, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_busy", busy, 0);
    sb.delete();
    src.delete();
    wcnt = 0;
    fd_cnt = 0;
    prev_full = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    in_empty = 1'b0;
    in_dout  = 24'hFFFFFF;
    out_full = 1'b0;
    #12;
    do_reset();

    // single pixel 10,20,30 -> 20, latency 2
    chk_lat = 1;
    src.push_back({8'd10, 8'd20, 8'd30});
    drain(20);

    // boundary values back-to-back
    src.push_back({8'd255, 8'd255, 8'd255});
    src.push_back({8'd255, 8'd255, 8'd254});
    src.push_back({8'd1,   8'd1,   8'd0});
    src.push_back({8'd0,   8'd0,   8'd2});
    src.push_back({8'd0,   8'd0,   8'd0});
    drain(20);

    // back-pressure mid-stream
    chk_lat = 0;
    for (int k = 0; k < 20; k++) src.push_back({3{8'(k)}});
    for (int i = 0; i < 12; i++) begin
      fullp = (i >= 6 && i < 11);
      cycle_once();
    end
    fullp = 0;
    drain(60);

    // frame wrap: 20 pixels, pulses on writes 8 and 16
    do_reset();
    for (int k = 0; k < 20; k++) src.push_back({8'(k*3), 8'(k*7), 8'(k*11)});
    drain(60);
    chk("fd_count", fd_cnt, 2);

    // upstream starvation: in_empty toggles each cycle
    wr_cnt = 0;
    for (int k = 0; k < 10; k++) src.push_back({8'(200 - k), 8'(k), 8'(k*13)});
    for (int i = 0; i < 60; i++) begin
      if (src.size() == 0 && sb.size() == 0) break;
      starve = i[0];
      cycle_once();
    end
    starve = 0;
    drain(20);
    chk("starve_writes", wr_cnt, 10);
    chk("starve_busy", busy, 0);

    // reset mid-frame with S1 and S2 holding pixels
    for (int k = 0; k < 12; k++) src.push_back({8'(k+50), 8'(k+60), 8'(k+70)});
    cycle_once();
    cycle_once();
    cycle_once();
    chk("pre_rst_busy", busy, 1);
    do_reset();
    for (int k = 0; k < 15; k++) src.push_back({8'(k*17), 8'(255 - k), 8'(k)});
    drain(60);
    chk("post_rst_fd", fd_cnt, 1);
    chk("post_rst_writes", wcnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gray_feeder.md
Name: gray_feeder

Overview:
Producer-side front end of the edge-detect pipeline. Drains 24-bit RGB pixels from an upstream first-word-fall-through (FWFT) FIFO and converts each to 8-bit grayscale. Writes the result into the 8-bit FIFO that the Sobel stage reads. Tracks raster position so it can flag end-of-frame, and never drops or duplicates a pixel under back-pressure.

Parameters:
WIDTH, 720, pixels per line
HEIGHT, 540, lines per frame

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_rd_en  out  1  pop request to upstream RGB FIFO
in_empty  in  1  upstream FIFO empty
in_dout  in  24  FWFT head pixel: [23:16]=R, [15:8]=G, [7:0]=B; valid whenever in_empty=0
out_wr_en  out  1  push strobe to Sobel input FIFO
out_full  in  1  Sobel input FIFO full
out_din  out  8  grayscale pixel
frame_done  out  1  one-cycle pulse coincident with the push of the last pixel of a frame
busy  out  1  any pipeline stage holds a valid pixel

Behaviour:
- Arithmetic:
  - sum = R+G+B, 10 bits unsigned.
  - gray = floor(sum/3), exact for all inputs; range 0..255, no saturation needed.
  - A divider-free form is permitted only if bit-exact, e.g. (sum*683)>>11 over a 21-bit product.
- Pipeline: two register stages.
  - S1 holds {s1_valid, sum}.
  - S2 holds {s2_valid, gray}.
- Advance enable: adv = !(s2_valid && out_full).
  - When adv=1, S2 loads S1 and S1 loads the new read.
  - When adv=0, both stages hold their contents.
- Read: in_rd_en = adv && !in_empty, combinational.
  - On a read, S1 captures sum of in_dout and s1_valid<=1.
  - If adv=1 with no read, s1_valid<=0.
- Write: out_wr_en = s2_valid && !out_full, combinational.
  - out_din = S2 gray register at all times.
  - A written pixel is consumed: S2 is reloaded from S1, or emptied, on the same edge.
- Latency: a pixel read in cycle N is pushed in cycle N+2 with no back-pressure. Full throughput is 1 pixel/cycle.
- No bubble on release: when out_full drops, the held S2 pixel is written that cycle while S1 advances.
- Raster counters x (0..WIDTH-1) and y (0..HEIGHT-1) advance only on out_wr_en.
  - At x=WIDTH-1: x<=0 and y increments.
  - At x=WIDTH-1 and y=HEIGHT-1: x<=0 and y<=0; the next frame starts with no gap.
- frame_done = out_wr_en && x==WIDTH-1 && y==HEIGHT-1, combinational.
- busy = s1_valid || s2_valid.
- Simultaneous events:
  - in_empty=0 together with out_full=1 and S2 valid: no read; everything holds.
  - Empty upstream with S1 valid: S1 drains into S2 normally.
- Reset, asynchronous and allowed mid-frame:
  - s1_valid, s2_valid, sum, gray, x and y go to 0.
  - Outputs during reset: in_rd_en=0, out_wr_en=0, out_din=0, frame_done=0, busy=0.
  - Pixels in flight are discarded and the first pixel after reset is treated as x=0,y=0.
  - Upstream and downstream FIFOs are reset by the same signal.

Test Plan:
- Single pixel R=10,G=20,B=30 into an empty pipe, out_full=0 -> in_rd_en at cycle N, out_wr_en with out_din=20 at cycle N+2, busy high N+1..N+2.
- Boundary values (255,255,255), (255,255,254), (1,1,0), (0,0,2), (0,0,0) streamed back-to-back -> outputs 255, 254, 0, 0, 0 on consecutive cycles.
- Back-pressure: stream 0..19 (R=G=B=k), out_full=1 for 5 cycles mid-stream -> output sequence exactly 0..19, no duplicates or gaps, in_rd_en low while stalled with S1/S2 full, first write on the cycle out_full falls.
- Frame wrap with WIDTH=4, HEIGHT=2, 20 pixels -> frame_done pulses on the 8th and 16th writes only; x/y return to 0 after each.
- Upstream starvation: in_empty toggles every cycle -> output order preserved, out_wr_en duty 50%, busy drops to 0 after the final pixel drains.
- Reset asserted mid-frame with S1 and S2 valid -> all outputs 0 immediately, in-flight pixels never written, next frame_done only after a full WIDTH*HEIGHT further writes.
